// File: rtl/btle_tx_framer_pkg.sv
// Shared definitions for the BTLE transmit framer: FSM states, PHY modes and
// frame-structure constants.
package btle_tx_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRE_AA    = 2'd1,
        ST_PDU       = 2'd2,
        ST_WAIT_LAST = 2'd3
    } tx_state_t;

    localparam logic LE_1M = 1'b0;
    localparam logic LE_2M = 1'b1;

    localparam int unsigned PRE_AA_BITS_1M = 40;
    localparam int unsigned PRE_AA_BITS_2M = 48;
    localparam int unsigned HDR_OCTETS     = 2;

endpackage

// File: rtl/btle_tx_framer_dpram.sv
// Simple dual-port octet RAM: one write port, one registered read port
// (one-cycle read latency, read-during-write returns the old contents).
module dpram #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
        read_data <= mem[read_address];
    end

endmodule

// File: rtl/btle_tx_framer.sv
// BTLE transmit framer: serialises preamble, access address and a PDU held in
// an internal octet RAM into an LSB-first bit stream for LE 1M / LE 2M.
module btle_tx_framer
    import btle_tx_framer_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT_1M = 16,
    parameter int unsigned PDU_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      phy_mode,
    input  logic [7:0]                preamble,
    input  logic [31:0]               access_address,
    input  logic [7:0]                len_mask,
    input  logic [PDU_ADDR_WIDTH-1:0] pdu_octet_mem_addr,
    input  logic [7:0]                pdu_octet_mem_data,
    input  logic                      pdu_octet_mem_we,
    input  logic                      tx_start,
    input  logic                      tx_abort,
    input  logic                      last_sample_done,
    output logic                      info_bit,
    output logic                      info_bit_valid,
    output logic                      info_bit_valid_last,
    output logic                      info_bit_pdu,
    output logic                      tx_busy,
    output logic                      tx_done
);

    localparam int unsigned     PH_W      = $clog2(CLK_PER_BIT_1M);
    localparam logic [PH_W-1:0] PH_MAX_1M = PH_W'(CLK_PER_BIT_1M - 1);
    localparam logic [PH_W-1:0] PH_MAX_2M = PH_W'(CLK_PER_BIT_1M / 2 - 1);

    tx_state_t                 state;
    tx_state_t                 state_nxt;
    logic [PH_W-1:0]           phase;
    logic [PH_W-1:0]           phase_nxt;
    logic                      bit_tick;
    logic                      pre_last;
    logic                      pdu_last;
    logic [11:0]               pdu_last_idx;
    logic                      mode_q;
    logic [7:0]                len_mask_q;
    logic [7:0]                len_q;
    logic [47:0]               pre_sr;
    logic [5:0]                pre_cnt;
    logic [11:0]               pdu_cnt;
    logic [6:0]                cur_oct;
    logic [PDU_ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]                rd_data;

    dpram #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (PDU_ADDR_WIDTH)
    ) u_pdu_mem (
        .clk           (clk),
        .write_enable  (pdu_octet_mem_we),
        .write_address (pdu_octet_mem_addr),
        .write_data    (pdu_octet_mem_data),
        .read_address  (rd_addr),
        .read_data     (rd_data)
    );

    assign tx_busy = (state != ST_IDLE);

    always_comb begin
        phase_nxt = (phase == ((mode_q == LE_2M) ? PH_MAX_2M : PH_MAX_1M)) ? '0 : phase + PH_W'(1);
        bit_tick  = (phase == '0);
        pre_last  = (mode_q == LE_2M) ? (pre_cnt == 6'(PRE_AA_BITS_2M - 1))
                                      : (pre_cnt == 6'(PRE_AA_BITS_1M - 1));
        // len_q is still 0 while the header is sent, so the last index cannot match early
        pdu_last_idx = ((12'(len_q) + 12'(HDR_OCTETS)) << 3) - 12'd1;
        pdu_last     = (pdu_cnt == pdu_last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (tx_start)             state_nxt = ST_PRE_AA;
            ST_PRE_AA:    if (bit_tick && pre_last) state_nxt = ST_PDU;
            ST_PDU:       if (bit_tick && pdu_last) state_nxt = ST_WAIT_LAST;
            ST_WAIT_LAST: if (last_sample_done)     state_nxt = ST_IDLE;
            default:                                state_nxt = ST_IDLE;
        endcase
        if (tx_abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // Outputs are registered: the bit is loaded on the phase-0 edge, so the
    // strobe is visible while phase equals 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase               <= '0;
            mode_q              <= LE_1M;
            len_mask_q          <= '0;
            len_q               <= '0;
            pre_sr              <= '0;
            pre_cnt             <= '0;
            pdu_cnt             <= '0;
            cur_oct             <= '0;
            rd_addr             <= '0;
            info_bit            <= 1'b0;
            info_bit_valid      <= 1'b0;
            info_bit_valid_last <= 1'b0;
            info_bit_pdu        <= 1'b0;
            tx_done             <= 1'b0;
        end else begin
            info_bit_valid      <= 1'b0;
            info_bit_valid_last <= 1'b0;
            info_bit_pdu        <= 1'b0;
            tx_done             <= 1'b0;
            if (tx_abort) begin
                phase <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_start) begin
                            mode_q     <= phy_mode;
                            len_mask_q <= len_mask;
                            len_q      <= '0;
                            pre_sr     <= (phy_mode == LE_2M) ? {access_address, preamble, preamble}
                                                              : {8'h00, access_address, preamble};
                            phase      <= '0;
                            pre_cnt    <= '0;
                            pdu_cnt    <= '0;
                            rd_addr    <= '0;
                        end
                    end
                    ST_PRE_AA: begin
                        phase <= phase_nxt;
                        if (bit_tick) begin
                            info_bit       <= pre_sr[0];
                            info_bit_valid <= 1'b1;
                            pre_sr         <= pre_sr >> 1;
                            pre_cnt        <= pre_cnt + 6'd1;
                        end
                    end
                    ST_PDU: begin
                        phase <= phase_nxt;
                        if (bit_tick) begin
                            info_bit_valid      <= 1'b1;
                            info_bit_pdu        <= 1'b1;
                            info_bit_valid_last <= pdu_last;
                            pdu_cnt             <= pdu_cnt + 12'd1;
                            // rd_data already holds this octet; advancing the address
                            // prefetches the next one during the remaining 7 bits
                            if (pdu_cnt[2:0] == 3'd0) begin
                                info_bit <= rd_data[0];
                                cur_oct  <= rd_data[7:1];
                                rd_addr  <= rd_addr + PDU_ADDR_WIDTH'(1);
                                if (pdu_cnt[11:3] == 9'(HDR_OCTETS - 1)) begin
                                    len_q <= rd_data & len_mask_q;
                                end
                            end else begin
                                info_bit <= cur_oct[0];
                                cur_oct  <= cur_oct >> 1;
                            end
                        end
                    end
                    ST_WAIT_LAST: begin
                        if (last_sample_done) begin
                            tx_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btle_tx_framer.sv
// Scoreboard bench for btle_tx_framer: stimulus queues expected strobes,
// a negedge monitor pops and compares every strobe and tx_done pulse.
module tb_btle_tx_framer;
    import btle_tx_framer_pkg::*;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          phy_mode = 1'b0;
    logic [7:0]    preamble = '0;
    logic [31:0]   access_address = '0;
    logic [7:0]    len_mask = '0;
    logic [AW-1:0] pdu_octet_mem_addr = '0;
    logic [7:0]    pdu_octet_mem_data = '0;
    logic          pdu_octet_mem_we = 1'b0;
    logic          tx_start = 1'b0;
    logic          tx_abort = 1'b0;
    logic          last_sample_done = 1'b0;
    logic          info_bit;
    logic          info_bit_valid;
    logic          info_bit_valid_last;
    logic          info_bit_pdu;
    logic          tx_busy;
    logic          tx_done;

    btle_tx_framer #(
        .CLK_PER_BIT_1M (CPB),
        .PDU_ADDR_WIDTH (AW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .phy_mode            (phy_mode),
        .preamble            (preamble),
        .access_address      (access_address),
        .len_mask            (len_mask),
        .pdu_octet_mem_addr  (pdu_octet_mem_addr),
        .pdu_octet_mem_data  (pdu_octet_mem_data),
        .pdu_octet_mem_we    (pdu_octet_mem_we),
        .tx_start            (tx_start),
        .tx_abort            (tx_abort),
        .last_sample_done    (last_sample_done),
        .info_bit            (info_bit),
        .info_bit_valid      (info_bit_valid),
        .info_bit_valid_last (info_bit_valid_last),
        .info_bit_pdu        (info_bit_pdu),
        .tx_busy             (tx_busy),
        .tx_done             (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic b;
        logic pdu;
        logic last;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  tb_mem [2**AW];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          exp_done_cyc = -1;
    int          done_seen = 0;
    int          frame_strobes = 0;
    int          frame_pdu = 0;
    int          last_strobe_cyc = -1;
    logic [15:0] first16 = '0;
    int          t0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe and every tx_done pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (info_bit_valid) begin
                if (frame_strobes < 16) first16[4'(frame_strobes)] = info_bit;
                frame_strobes++;
                if (info_bit_pdu) frame_pdu++;
                if (info_bit_valid_last) last_strobe_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got valid=1, expected no strobe (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_time", cyc, e.cyc);
                    check("strobe_bits", {info_bit, info_bit_pdu, info_bit_valid_last}, {e.b, e.pdu, e.last});
                end
            end
            if (tx_done) begin
                done_seen = 1;
                check("tx_done_time", cyc, exp_done_cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        pdu_octet_mem_we   = 1'b1;
        pdu_octet_mem_addr = AW'(a);
        pdu_octet_mem_data = d;
        tb_mem[a]          = d;
        step();
        pdu_octet_mem_we   = 1'b0;
    endtask

    // Expected stream: preamble (twice in 2M), AA, then mem[k>>3][k&7], all LSB-first.
    task automatic push_frame(input logic mode, input logic [7:0] pre, input logic [31:0] aa,
                              input logic [7:0] mask, input int ts, input int limit);
        int p;
        int pa;
        int pdu_bits;
        int total;
        p        = (mode == LE_2M) ? int'(CPB / 2) : int'(CPB);
        pa       = (mode == LE_2M) ? 48 : 40;
        pdu_bits = (int'(tb_mem[1] & mask) + 2) * 8;
        total    = pa + pdu_bits;
        if (limit >= 0 && limit < total) total = limit;
        for (int n = 0; n < total; n++) begin
            exp_t       e;
            logic [7:0] oct;
            int         k;
            e.cyc  = ts + 2 + n * p;
            e.pdu  = 1'b0;
            e.last = 1'b0;
            if (n < 8) begin
                e.b = pre[n];
            end else if (mode == LE_2M && n < 16) begin
                e.b = pre[n - 8];
            end else if (n < pa) begin
                e.b = aa[n - (pa - 32)];
            end else begin
                k      = n - pa;
                oct    = tb_mem[k >> 3];
                e.b    = oct[k & 7];
                e.pdu  = 1'b1;
                e.last = (k == pdu_bits - 1);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic mode, input logic [7:0] pre, input logic [31:0] aa,
                               input logic [7:0] mask, input int limit, output int ts);
        phy_mode       = mode;
        preamble       = pre;
        access_address = aa;
        len_mask       = mask;
        tx_start       = 1'b1;
        ts             = cyc;
        exp_done_cyc   = -1;
        done_seen      = 0;
        frame_strobes  = 0;
        frame_pdu      = 0;
        push_frame(mode, pre, aa, mask, ts, limit);
        step();
        tx_start       = 1'b0;
        phy_mode       = ~mode;
        preamble       = ~pre;
        access_address = ~aa;
        len_mask       = 8'h00;
        check("busy_after_start", tx_busy, 1);
    endtask

    task automatic finish_frame(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
        step();
        check("busy_wait_last", tx_busy, 1);
        last_sample_done = 1'b1;
        exp_done_cyc     = cyc + 1;
        step();
        last_sample_done = 1'b0;
        check("busy_after_done", tx_busy, 0);
        step();
        check("done_seen", done_seen, 1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) tb_mem[i] = 8'h00;
        repeat (3) step();
        check("reset_outputs", {info_bit, info_bit_valid, info_bit_valid_last, info_bit_pdu, tx_busy, tx_done}, 0);
        rst = 1'b0;
        step();

        // 1M golden frame, with tx_start and last_sample_done noise during PRE_AA
        wr(0, 8'h02);
        wr(1, 8'h00);
        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'hFF, -1, t0);
        repeat (100) step();
        tx_start         = 1'b1;
        last_sample_done = 1'b1;
        step();
        tx_start         = 1'b0;
        last_sample_done = 1'b0;
        finish_frame(2000);
        check("A_strobes", frame_strobes, 56);
        check("A_pdu_strobes", frame_pdu, 16);
        check("A_last_cycle", last_strobe_cyc, t0 + 2 + 55 * 16);

        // 2M frame, L=3
        wr(0, 8'h40);
        wr(1, 8'h03);
        wr(2, 8'h11);
        wr(3, 8'h22);
        wr(4, 8'h33);
        start_frame(LE_2M, 8'h55, 32'h8E89BED6, 8'hFF, -1, t0);
        finish_frame(2000);
        check("B_strobes", frame_strobes, 88);
        check("B_pdu_strobes", frame_pdu, 40);
        check("B_first16", first16, 16'h5555);
        check("B_last_cycle", last_strobe_cyc, t0 + 2 + 87 * 8);

        // len_mask 0x1F on header 0xE5 gives L=5
        wr(0, 8'h11);
        wr(1, 8'hE5);
        wr(2, 8'hA5);
        wr(3, 8'h3C);
        wr(4, 8'h0F);
        wr(5, 8'hF0);
        wr(6, 8'h96);
        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'h1F, -1, t0);
        finish_frame(3000);
        check("C_strobes", frame_strobes, 96);
        check("C_pdu_strobes", frame_pdu, 56);

        // abort during PDU bit 20 (strobe index 60)
        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'h1F, 61, t0);
        wait_cyc(t0 + 2 + 60 * 16);
        tx_abort = 1'b1;
        step();
        tx_abort = 1'b0;
        check("abort_outputs", {tx_busy, info_bit_valid, info_bit_valid_last, tx_done}, 0);
        repeat (64) step();
        check("abort_strobes", frame_strobes, 61);
        check("abort_no_done", done_seen, 0);

        // start together with abort in IDLE stays IDLE
        tx_start = 1'b1;
        tx_abort = 1'b1;
        step();
        tx_start = 1'b0;
        tx_abort = 1'b0;
        check("start_abort_idle", tx_busy, 0);
        repeat (40) step();

        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'h1F, -1, t0);
        finish_frame(3000);
        check("C2_pdu_strobes", frame_pdu, 56);

        // reset during PDU bit 10 (strobe index 50), then the golden frame again
        wr(0, 8'h02);
        wr(1, 8'h00);
        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'hFF, 51, t0);
        wait_cyc(t0 + 2 + 50 * 16);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outputs", {info_bit, info_bit_valid, info_bit_valid_last, info_bit_pdu, tx_busy, tx_done}, 0);
        repeat (40) step();
        check("rst_strobes", frame_strobes, 51);
        start_frame(LE_1M, 8'hAA, 32'h8E89BED6, 8'hFF, -1, t0);
        finish_frame(2000);
        check("A2_strobes", frame_strobes, 56);
        check("A2_last_cycle", last_strobe_cyc, t0 + 2 + 55 * 16);

        // maximum payload L=255 in 2M: 2056 PDU bits, every period exactly 8 clocks
        for (int a = 0; a < 257; a++) begin
            wr(a, (a == 1) ? 8'hFF : 8'((a * 37 + 5) & 255));
        end
        start_frame(LE_2M, 8'h55, 32'h8E89BED6, 8'hFF, -1, t0);
        finish_frame(17500);
        check("D_pdu_strobes", frame_pdu, 2056);
        check("D_last_cycle", last_strobe_cyc, t0 + 2 + 2103 * 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
